jtag_tap: RTL

- IEEE 1149.1 TAP controller with instruction register, IDCODE, BYPASS and one user scan data register.
- Consumes the pin-level TMS/TDI presented by the top-level wrapper and produces TDO back to it.
- TCK is the block clock. The system reset doubles as TRST.
- The USER register exposes a parallel output and input so that later on-chip logic can be controlled and observed over JTAG.

---
 rtl/jtag_pkg.sv | 34 +++
 rtl/jtag_tap_fsm.sv | 64 ++++++
 rtl/jtag_tap.sv | 135 +++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared types and instruction codes for the JTAG TAP controller.
// The state encodings are fixed because tap_state is observed externally.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_t;

    localparam logic [3:0] INSTR_IDCODE = 4'b0001;
    localparam logic [3:0] INSTR_USER   = 4'b0010;
    localparam logic [3:0] INSTR_BYPASS = 4'b1111;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: TMS-driven state register, next-state
// logic and the decoded per-state strobes used by the scan registers.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tms,
    output tap_state_t state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       tlr
);

    tap_state_t state_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is assigned before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            TLR:    state_nxt = tms ? TLR    : RTI;
            RTI:    state_nxt = tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = tms ? SEL_DR : RTI;
            SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
            CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    assign capture_dr = (state == CAP_DR);
    assign shift_dr   = (state == SH_DR);
    assign update_dr  = (state == UPD_DR);
    assign capture_ir = (state == CAP_IR);
    assign shift_ir   = (state == SH_IR);
    assign update_ir  = (state == UPD_IR);
    assign tlr        = (state == TLR);

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP with instruction register, IDCODE, BYPASS and a USER scan
// register exposing parallel capture/update ports to on-chip logic.
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0FFF,
    parameter int          USER_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    input  logic [USER_WIDTH-1:0] user_in,
    output logic [USER_WIDTH-1:0] user_out,
    output logic                  user_update,
    output logic [3:0]            tap_state
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(INSTR_USER);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = IR_WIDTH'(INSTR_BYPASS);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_t state;
    logic capture_dr, shift_dr, update_dr;
    logic capture_ir, shift_ir, update_ir, tlr;

    logic [IR_WIDTH-1:0]   ir_shift;
    logic [IR_WIDTH-1:0]   ir_reg;
    logic [31:0]           idcode_shift;
    logic                  bypass_reg;
    logic [USER_WIDTH-1:0] user_shift;
    dr_sel_t               dr_sel;

    jtag_tap_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .tms        (tms),
        .state      (state),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .tlr        (tlr)
    );

    assign tap_state = state;

    // Instruction register: shift stage plus the update stage that drives decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_shift <= '0;
            ir_reg   <= IR_IDCODE;
        end else begin
            if (capture_ir) begin
                ir_shift <= IR_CAPTURE;
            end else if (shift_ir) begin
                ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
            end
            if (tlr) begin
                ir_reg <= IR_IDCODE;
            end else if (update_ir) begin
                ir_reg <= ir_shift;
            end
        end
    end

    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_reg)
            IR_IDCODE: dr_sel = DR_IDCODE;
            IR_USER:   dr_sel = DR_USER;
            IR_BYPASS: dr_sel = DR_BYPASS;
            default:   dr_sel = DR_BYPASS;
        endcase
    end

    // Only the selected data register captures or shifts; the others hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idcode_shift <= '0;
            bypass_reg   <= 1'b0;
            user_shift   <= '0;
        end else begin
            case (dr_sel)
                DR_IDCODE: begin
                    if (capture_dr)    idcode_shift <= IDCODE_VAL;
                    else if (shift_dr) idcode_shift <= {tdi, idcode_shift[31:1]};
                end
                DR_USER: begin
                    if (capture_dr)    user_shift <= user_in;
                    else if (shift_dr) user_shift <= {tdi, user_shift[USER_WIDTH-1:1]};
                end
                default: begin
                    if (capture_dr)    bypass_reg <= 1'b0;
                    else if (shift_dr) bypass_reg <= tdi;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            user_out    <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= update_dr && (dr_sel == DR_USER);
            if (update_dr && (dr_sel == DR_USER)) begin
                user_out <= user_shift;
            end
        end
    end

    // tdo comes straight from flops so the first bit is valid on entry to Shift.
    always_comb begin
        tdo = 1'b0;
        if (shift_ir) begin
            tdo = ir_shift[0];
        end else if (shift_dr) begin
            case (dr_sel)
                DR_IDCODE: tdo = idcode_shift[0];
                DR_USER:   tdo = user_shift[0];
                default:   tdo = bypass_reg;
            endcase
        end
    end

    assign tdo_en = shift_ir | shift_dr;

endmodule
